// File: rtl/bus_pkg.sv
// Shared definitions for the MMU-to-AXI4-Lite bridge: FSM states, AXI response
// codes and request-mode encodings.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/mem_axi_bridge.sv
// Single-outstanding MMU memory request to AXI4-Lite master bridge.
// All outputs are registered; one completion pulse per accepted request.
module mem_axi_bridge
    import bus_pkg::*;
#(
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        request_enable,
    input  logic        req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,

    output logic        response_enable,
    output logic [31:0] resp_data,
    output logic        bus_error,
    output logic        busy,

    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,

    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,

    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,

    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] resp_data_reg;
    logic        arvalid_reg;
    logic        rready_reg;
    logic        awvalid_reg;
    logic        wvalid_reg;
    logic        bready_reg;
    logic        aw_done_reg;
    logic        w_done_reg;
    logic        response_enable_reg;
    logic        bus_error_reg;
    logic        busy_reg;

    logic        aw_done_next;
    logic        w_done_next;

    // A channel counts as done once it has handshaken, including this cycle.
    assign aw_done_next = aw_done_reg | (awvalid_reg & m_axi_awready);
    assign w_done_next  = w_done_reg  | (wvalid_reg  & m_axi_wready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg           <= IDLE;
            addr_reg            <= '0;
            wdata_reg           <= '0;
            wstrb_reg           <= '0;
            resp_data_reg       <= '0;
            arvalid_reg         <= 1'b0;
            rready_reg          <= 1'b0;
            awvalid_reg         <= 1'b0;
            wvalid_reg          <= 1'b0;
            bready_reg          <= 1'b0;
            aw_done_reg         <= 1'b0;
            w_done_reg          <= 1'b0;
            response_enable_reg <= 1'b0;
            bus_error_reg       <= 1'b0;
            busy_reg            <= 1'b0;
        end else begin
            response_enable_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (request_enable) begin
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        wstrb_reg <= req_wstrb;
                        busy_reg  <= 1'b1;
                        unique case (req_mode)
                            REQ_READ: begin
                                arvalid_reg <= 1'b1;
                                state_reg   <= RD_ADDR;
                            end
                            REQ_WRITE: begin
                                awvalid_reg <= 1'b1;
                                wvalid_reg  <= 1'b1;
                                state_reg   <= WR_REQ;
                            end
                        endcase
                    end
                end
                RD_ADDR: begin
                    if (arvalid_reg && m_axi_arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid && rready_reg) begin
                        resp_data_reg       <= m_axi_rdata;
                        bus_error_reg       <= (m_axi_rresp != AXI_RESP_OKAY);
                        rready_reg          <= 1'b0;
                        response_enable_reg <= 1'b1;
                        state_reg           <= DONE;
                    end
                end
                WR_REQ: begin
                    if (awvalid_reg && m_axi_awready) begin
                        awvalid_reg <= 1'b0;
                    end
                    if (wvalid_reg && m_axi_wready) begin
                        wvalid_reg <= 1'b0;
                    end
                    if (aw_done_next && w_done_next) begin
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        bready_reg  <= 1'b1;
                        state_reg   <= WR_RESP;
                    end else begin
                        aw_done_reg <= aw_done_next;
                        w_done_reg  <= w_done_next;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid && bready_reg) begin
                        resp_data_reg       <= '0;
                        bus_error_reg       <= (m_axi_bresp != AXI_RESP_OKAY);
                        bready_reg          <= 1'b0;
                        response_enable_reg <= 1'b1;
                        state_reg           <= DONE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign response_enable = response_enable_reg;
    assign resp_data       = resp_data_reg;
    assign bus_error       = bus_error_reg;
    assign busy            = busy_reg;

    assign m_axi_awaddr    = addr_reg;
    assign m_axi_awprot    = AXI_PROT;
    assign m_axi_awvalid   = awvalid_reg;
    assign m_axi_wdata     = wdata_reg;
    assign m_axi_wstrb     = wstrb_reg;
    assign m_axi_wvalid    = wvalid_reg;
    assign m_axi_bready    = bready_reg;
    assign m_axi_araddr    = addr_reg;
    assign m_axi_arprot    = AXI_PROT;
    assign m_axi_arvalid   = arvalid_reg;
    assign m_axi_rready    = rready_reg;

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Bench for mem_axi_bridge: an open-loop scripted AXI slave plus a cycle-accurate
// expectation derived from handshake cycle arithmetic.
module tb_mem_axi_bridge;
    import bus_pkg::*;

    logic        clk;
    logic        rst;
    logic        request_enable;
    logic        req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        response_enable;
    logic [31:0] resp_data;
    logic        bus_error;
    logic        busy;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int          checks;
    int          passes;
    logic [31:0] prev_data;
    logic        prev_err;

    mem_axi_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .request_enable  (request_enable),
        .req_mode        (req_mode),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_wstrb       (req_wstrb),
        .response_enable (response_enable),
        .resp_data       (resp_data),
        .bus_error       (bus_error),
        .busy            (busy),
        .m_axi_awaddr    (m_axi_awaddr),
        .m_axi_awprot    (m_axi_awprot),
        .m_axi_awvalid   (m_axi_awvalid),
        .m_axi_awready   (m_axi_awready),
        .m_axi_wdata     (m_axi_wdata),
        .m_axi_wstrb     (m_axi_wstrb),
        .m_axi_wvalid    (m_axi_wvalid),
        .m_axi_wready    (m_axi_wready),
        .m_axi_bresp     (m_axi_bresp),
        .m_axi_bvalid    (m_axi_bvalid),
        .m_axi_bready    (m_axi_bready),
        .m_axi_araddr    (m_axi_araddr),
        .m_axi_arprot    (m_axi_arprot),
        .m_axi_arvalid   (m_axi_arvalid),
        .m_axi_arready   (m_axi_arready),
        .m_axi_rdata     (m_axi_rdata),
        .m_axi_rresp     (m_axi_rresp),
        .m_axi_rvalid    (m_axi_rvalid),
        .m_axi_rready    (m_axi_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every output, concatenated, for "everything is zero" comparisons.
    function automatic logic [145:0] all_outputs();
        return {response_enable, resp_data, bus_error, busy,
                m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
                m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
                m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready};
    endfunction

    task automatic idle_slave();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
    endtask

    // One transaction; called and returns at posedge+1. Cycle 0 carries the request.
    // Slave delays are counted from the earliest cycle each handshake could occur.
    task automatic run_txn(input string name, input logic mode, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int ar_d, input int r_d, input int aw_d, input int w_d,
                           input int b_d, input logic [31:0] rdata, input logic [1:0] resp,
                           input int intr_c, input int tail);
        int ha, hr, haw, hw, hb0, hb, rc, ic;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [6:0]  exp_ctrl;
        logic [6:0]  obs_ctrl;
        ha = 0; hr = 0; haw = 0; hw = 0; hb0 = 0; hb = 0;
        if (mode == REQ_READ) begin
            ha = 1 + ar_d;
            hr = ha + 1 + r_d;
            rc = hr + 1;
            exp_data = rdata;
        end else begin
            haw = 1 + aw_d;
            hw  = 1 + w_d;
            hb0 = ((haw > hw) ? haw : hw) + 1;
            hb  = hb0 + b_d;
            rc  = hb + 1;
            exp_data = 32'h0;
        end
        exp_err = (resp != AXI_RESP_OKAY);
        ic = (intr_c > rc) ? rc : intr_c;

        for (int c = 0; c <= rc + tail; c++) begin
            request_enable = (c == 0) || (ic >= 1 && c == ic);
            req_mode  = (c == 0) ? mode  : ~mode;
            req_addr  = (c == 0) ? addr  : (addr ^ 32'hFFFF_0000);
            req_wdata = (c == 0) ? wdata : $urandom;
            req_wstrb = (c == 0) ? wstrb : ~wstrb;
            m_axi_arready = (mode == REQ_READ)  && (c == ha);
            m_axi_rvalid  = (mode == REQ_READ)  && (c == hr);
            m_axi_rdata   = m_axi_rvalid ? rdata : $urandom;
            m_axi_rresp   = m_axi_rvalid ? resp : 2'($urandom);
            m_axi_awready = (mode == REQ_WRITE) && (c == haw);
            m_axi_wready  = (mode == REQ_WRITE) && (c == hw);
            m_axi_bvalid  = (mode == REQ_WRITE) && (c == hb);
            m_axi_bresp   = m_axi_bvalid ? resp : 2'($urandom);

            @(negedge clk);
            exp_ctrl = {c == rc,
                        c >= 1 && c <= rc,
                        mode == REQ_READ  && c >= 1 && c <= ha,
                        mode == REQ_READ  && c > ha && c <= hr,
                        mode == REQ_WRITE && c >= 1 && c <= haw,
                        mode == REQ_WRITE && c >= 1 && c <= hw,
                        mode == REQ_WRITE && c >= hb0 && c <= hb};
            obs_ctrl = {response_enable, busy, m_axi_arvalid, m_axi_rready,
                        m_axi_awvalid, m_axi_wvalid, m_axi_bready};
            checks++;
            if (obs_ctrl !== exp_ctrl)
                $display("FAIL %s ctrl cyc %0d: got {resp,busy,arv,rr,awv,wv,br}=%b want %b",
                         name, c, obs_ctrl, exp_ctrl);
            else passes++;

            if (exp_ctrl[4]) begin
                checks++;
                if (m_axi_araddr !== addr)
                    $display("FAIL %s araddr cyc %0d: got %h want %h", name, c, m_axi_araddr, addr);
                else passes++;
            end
            if (exp_ctrl[2]) begin
                checks++;
                if (m_axi_awaddr !== addr)
                    $display("FAIL %s awaddr cyc %0d: got %h want %h", name, c, m_axi_awaddr, addr);
                else passes++;
            end
            if (exp_ctrl[1]) begin
                checks++;
                if ({m_axi_wdata, m_axi_wstrb} !== {wdata, wstrb})
                    $display("FAIL %s wdata/wstrb cyc %0d: got %h/%b want %h/%b",
                             name, c, m_axi_wdata, m_axi_wstrb, wdata, wstrb);
                else passes++;
            end
            checks++;
            if ({resp_data, bus_error} !== ((c >= rc) ? {exp_data, exp_err} : {prev_data, prev_err}))
                $display("FAIL %s resp cyc %0d: got data=%h err=%b want data=%h err=%b", name, c,
                         resp_data, bus_error, (c >= rc) ? exp_data : prev_data,
                         (c >= rc) ? exp_err : prev_err);
            else passes++;

            @(posedge clk);
            #1;
        end
        request_enable = 1'b0;
        idle_slave();
        prev_data = exp_data;
        prev_err  = exp_err;
        $display("txn %s mode=%0d addr=%h resp_cycle=%0d data=%h err=%b",
                 name, mode, addr, rc, exp_data, exp_err);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        request_enable = 1'b0;
        req_mode = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        idle_slave();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outputs() !== '0)
            $display("FAIL reset_outputs: got %h want 0", all_outputs());
        else passes++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (all_outputs() !== '0)
            $display("FAIL after_reset_idle: got %h want 0", all_outputs());
        else passes++;
        @(posedge clk);
        #1;
        prev_data = '0;
        prev_err  = 1'b0;
        $display("txn reset: outputs checked zero");
    endtask

    task automatic test_read_zero_wait();
        run_txn("read_zero_wait", REQ_READ, 32'h8000_0010, 32'h0, 4'h0,
                0, 0, 0, 0, 0, 32'hDEAD_BEEF, AXI_RESP_OKAY, 0, 2);
    endtask

    task automatic test_write_aw_first();
        run_txn("write_aw_first", REQ_WRITE, 32'h1000_0004, 32'h0000_00AB, 4'b0001,
                0, 0, 0, 3, 0, 32'h0, AXI_RESP_OKAY, 0, 2);
    endtask

    task automatic test_write_slverr();
        run_txn("write_slverr", REQ_WRITE, $urandom, $urandom, 4'b1111,
                0, 0, 2, 2, 1, 32'h0, AXI_RESP_SLVERR, 0, 2);
    endtask

    task automatic test_read_slow_err();
        run_txn("read_slow_decerr", REQ_READ, $urandom, 32'h0, 4'h0,
                1, 7, 0, 0, 0, $urandom, AXI_RESP_DECERR, 0, 2);
    endtask

    task automatic test_busy_ignore();
        run_txn("busy_ignore_read", REQ_READ, 32'h2000_0100, 32'h0, 4'h0,
                1, 2, 0, 0, 0, 32'h1234_5678, AXI_RESP_OKAY, 3, 3);
        run_txn("busy_ignore_wr_done", REQ_WRITE, 32'h3000_0008, 32'hCAFE_F00D, 4'b1100,
                0, 0, 1, 0, 0, 32'h0, AXI_RESP_OKAY, 99, 3);
    endtask

    task automatic test_reset_mid();
        request_enable = 1'b1;
        req_mode  = REQ_READ;
        req_addr  = 32'h4000_0040;
        req_wdata = $urandom;
        req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        request_enable = 1'b0;
        m_axi_arready = 1'b1;
        @(posedge clk);
        #1;
        m_axi_arready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({m_axi_rready, busy} !== 2'b11)
            $display("FAIL reset_mid_in_rd_data: got rready,busy=%b want 11", {m_axi_rready, busy});
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (all_outputs() !== '0)
            $display("FAIL reset_mid_async_zero: got %h want 0", all_outputs());
        else passes++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        idle_slave();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({response_enable, busy, m_axi_rready} !== 3'b000)
                $display("FAIL reset_mid_no_response: got resp,busy,rready=%b want 000",
                         {response_enable, busy, m_axi_rready});
            else passes++;
            @(posedge clk);
            #1;
        end
        prev_data = '0;
        prev_err  = 1'b0;
        $display("txn reset_mid: abandoned read, outputs cleared");
        run_txn("read_after_reset", REQ_READ, 32'h4000_0044, 32'h0, 4'h0,
                0, 1, 0, 0, 0, 32'h0BAD_F00D, AXI_RESP_OKAY, 0, 2);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_write", REQ_WRITE, $urandom, $urandom, 4'($urandom),
                0, 0, 0, 0, 0, 32'h0, AXI_RESP_OKAY, 0, 0);
        run_txn("b2b_read", REQ_READ, $urandom, 32'h0, 4'h0,
                0, 0, 0, 0, 0, $urandom, AXI_RESP_SLVERR, 0, 0);
        run_txn("b2b_read2", REQ_READ, $urandom, 32'h0, 4'h0,
                0, 0, 0, 0, 0, $urandom, AXI_RESP_OKAY, 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_txn($sformatf("random_%0d", n), 1'($urandom), $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom, 2'($urandom),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 12) : 0,
                    $urandom_range(0, 2));
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_read_zero_wait();
        test_write_aw_first();
        test_write_slverr();
        test_read_slow_err();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_axi_bridge.md
# mem_axi_bridge

Converts the single-outstanding physical memory request issued by the MMU (`request_enable`/`req_*` in, `response_enable`/`resp_data` out) into AXI4-Lite master transactions on the system bus. It sits directly downstream of `mmu`, between the MMU and the interconnect/RAM/MMIO. It holds one request at a time, drives the five AXI channels, and returns a one-cycle response pulse carrying read data or write completion.

## Interface
- `AXI_PROT`, default `3'b000`: constant driven on `m_axi_arprot`/`m_axi_awprot`.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `request_enable` in 1: one-cycle request strobe from the MMU.
- `req_mode` in 1: 0 = read, 1 = write.
- `req_addr` in 32: physical byte address.
- `req_wdata` in 32, `req_wstrb` in 4: write data and byte strobes, used only when `req_mode` = 1.
- `response_enable` out 1: one-cycle completion pulse to the MMU.
- `resp_data` out 32: read data; 0 for writes.
- `bus_error` out 1: high together with `response_enable` when RRESP/BRESP ≠ OKAY (2'b00).
- `busy` out 1: high from request acceptance through the cycle of `response_enable`.
- AXI write address: `m_axi_awaddr` out 32, `m_axi_awprot` out 3, `m_axi_awvalid` out 1, `m_axi_awready` in 1.
- AXI write data: `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wvalid` out 1, `m_axi_wready` in 1.
- AXI write response: `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1.
- AXI read address: `m_axi_araddr` out 32, `m_axi_arprot` out 3, `m_axi_arvalid` out 1, `m_axi_arready` in 1.
- AXI read data: `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1.

## Operation
- States:
  - IDLE
  - RD_ADDR
  - RD_DATA
  - WR_REQ
  - WR_RESP
  - DONE
- IDLE: on `request_enable`, latch address, data, strobes and mode into registers. Read → RD_ADDR with `arvalid`=1. Write → WR_REQ with `awvalid`=`wvalid`=1.
- RD_ADDR: hold `arvalid` until `arready`. On the handshake, drop `arvalid`, raise `rready`, go to RD_DATA.
- RD_DATA: on `rvalid`&&`rready`, capture `rdata` and `bus_error`=(`rresp`≠0), drop `rready`, go to DONE.
- WR_REQ: AW and W are independent. Each valid drops on its own handshake, tracked by flags `aw_done` and `w_done`. When both are done (same cycle allowed), raise `bready`, go to WR_RESP.
- WR_RESP: on `bvalid`&&`bready`, set `bus_error`=(`bresp`≠0), set `resp_data`=0, drop `bready`, go to DONE.
- DONE: assert `response_enable` for exactly one cycle, then return to IDLE.
- AXI payloads (addr, data, strobes) come from the latched registers and stay stable while the corresponding valid is high.
- `request_enable` while `busy`=1 is a protocol violation. It is ignored: no latch, no state change.
- A bus error does not raise an exception here. The MMU/core decides what to do with `bus_error`.

## Timing
- Reset: asynchronous, active-high. All outputs are 0: every valid/ready, `response_enable`, `bus_error`, `busy`, `resp_data`, and all address/data/strobe registers. State = IDLE, flags cleared.
- Reset mid-transaction abandons the transaction; no response is produced.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Minimum read latency with `arready`=`rvalid`=1 immediately, counting `request_enable` at cycle 0:
  - `arvalid` high at cycle 1.
  - `rready` high at cycle 2.
  - `response_enable` at cycle 3.
- Minimum write latency under the same conditions:
  - AW/W valid at cycle 1.
  - `bready` at cycle 2.
  - `response_enable` at cycle 3.
- A new `request_enable` is accepted in the cycle after `response_enable` (IDLE). Back-to-back throughput is one request per 4 cycles minimum.
- Indefinite ready/valid stalls simply hold the state; there is no timeout.
- `resp_data` and `bus_error` hold their values until the next completion.

## Structure
- Shared package `bus_pkg` holds:
  - State enum.
  - `AXI_RESP_OKAY`/`SLVERR`/`DECERR` constants.
  - `REQ_READ`=0 / `REQ_WRITE`=1.
- Single flat module, no sub-module.

## Test plan
- Read with zero-wait slave: read at 0x8000_0010, `rdata`=0xDEADBEEF → `araddr`=0x8000_0010, `response_enable` exactly at cycle 3, `resp_data`=0xDEADBEEF, `bus_error`=0.
- Write with AW before W: write at 0x1000_0004, wdata=0x0000_00AB, wstrb=4'b0001. Slave raises `awready` at cycle 1 and `wready` at cycle 4 → `awvalid` drops after cycle 1, `wvalid` stays until cycle 4, `bready` at cycle 5, one `response_enable`, `resp_data`=0.
- Simultaneous AW/W handshake plus `bresp`=2'b10 → `response_enable` with `bus_error`=1.
- Read with `rvalid` delayed 7 cycles and `rresp`=2'b11 → `rready` held throughout, `bus_error`=1, `busy`=1 until completion.
- `request_enable` pulsed while busy with a different address → ignored: AXI addresses unchanged, exactly one response.
- `rst` asserted in RD_DATA → all outputs 0 asynchronously; a subsequent read completes normally.
